// File: rtl/uart_transmitter_if.sv
// Parallel-side handshake bundle for the UART transmitter: request/data in, serial line and status
// out.
interface uart_transmitter_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 tx_start;
  logic [DATA_BITS-1:0] data_in;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;

  modport master (
    output tx_start,
    output data_in,
    input  tx,
    input  busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  data_in,
    output tx,
    output busy,
    output tx_done
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: accepts a parallel word via tx_start/busy and emits one asynchronous frame
// (start, LSB-first data, optional parity, stop bits) on a registered tx line.
module uart_transmitter #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic              clk,
  input logic              rst,
  uart_transmitter_if.slave bus
);

  localparam int unsigned StopCycles = STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned CntW       = $clog2(StopCycles + 1);
  localparam int unsigned BitW       = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e               state_q;
  logic [CntW-1:0]      baud_cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 tx_done_q;

  logic baud_last;
  logic stop_last;
  logic data_last;

  assign baud_last = (baud_cnt_q == CntW'(CLKS_PER_BIT - 1));
  // All stop bits are timed as one long period so the counter never needs a second level.
  assign stop_last = (baud_cnt_q == CntW'(StopCycles - 1));
  assign data_last = (bit_cnt_q == BitW'(DATA_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          tx_q       <= 1'b1;
          if (bus.tx_start) begin
            shift_q  <= bus.data_in;
            parity_q <= (^bus.data_in) ^ (PARITY_ODD != 0);
            busy_q   <= 1'b1;
            tx_q     <= 1'b0;
            state_q  <= StStart;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= shift_q[0];
            state_q    <= StData;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            if (data_last) begin
              if (PARITY_EN != 0) begin
                tx_q    <= parity_q;
                state_q <= StParity;
              end else begin
                tx_q    <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              // Present the next LSB on the same edge the register shifts.
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        StParity: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
            state_q    <= StStop;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (stop_last) begin
            baud_cnt_q <= '0;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b1;
            state_q    <= StIdle;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: three instances cover even/odd parity at 4 clocks per bit
// and a no-parity, two-stop, one-clock-per-bit configuration.
module tb_uart_transmitter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_transmitter_if #(.DATA_BITS(8)) if_even ();
  uart_transmitter_if #(.DATA_BITS(8)) if_odd ();
  uart_transmitter_if #(.DATA_BITS(8)) if_fast ();

  uart_transmitter #(
    .DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_even (
    .clk(clk),
    .rst(rst),
    .bus(if_even)
  );

  uart_transmitter #(
    .DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
  ) dut_odd (
    .clk(clk),
    .rst(rst),
    .bus(if_odd)
  );

  uart_transmitter #(
    .DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)
  ) dut_fast (
    .clk(clk),
    .rst(rst),
    .bus(if_fast)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic start, input logic [7:0] data);
    case (sel)
      0: begin if_even.tx_start = start; if_even.data_in = data; end
      1: begin if_odd.tx_start = start;  if_odd.data_in = data;  end
      default: begin if_fast.tx_start = start; if_fast.data_in = data; end
    endcase
  endtask

  task automatic set_start(input int sel, input logic start);
    case (sel)
      0: if_even.tx_start = start;
      1: if_odd.tx_start = start;
      default: if_fast.tx_start = start;
    endcase
  endtask

  task automatic sample(input int sel, output logic t, output logic b, output logic d);
    case (sel)
      0: begin t = if_even.tx; b = if_even.busy; d = if_even.tx_done; end
      1: begin t = if_odd.tx;  b = if_odd.busy;  d = if_odd.tx_done;  end
      default: begin t = if_fast.tx; b = if_fast.busy; d = if_fast.tx_done; end
    endcase
  endtask

  task automatic chk_idle(input int sel, input string tag);
    logic t, b, d;
    sample(sel, t, b, d);
    chk({tag, ".tx"}, t, 1'b1);
    chk({tag, ".busy"}, b, 1'b0);
    chk({tag, ".tx_done"}, d, 1'b0);
  endtask

  // Sends one frame and checks tx/busy/tx_done every cycle up to the tx_done edge.
  // hold keeps tx_start high afterwards; inj >= 0 pulses tx_start with 8'h3C mid-frame.
  task automatic send(input int sel, input logic [7:0] d, input int cpb, input int pe,
                      input logic par, input int stops, input bit hold, input int inj,
                      input string tag);
    logic slots[16];
    int   n;
    logic t, b, dn;
    n = 0;
    slots[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin slots[n] = d[i]; n++; end
    if (pe != 0) begin slots[n] = par; n++; end
    for (int i = 0; i < stops; i++) begin slots[n] = 1'b1; n++; end
    drive(sel, 1'b1, d);
    tick();
    if (!hold) set_start(sel, 1'b0);
    for (int k = 0; k < n * cpb; k++) begin
      sample(sel, t, b, dn);
      chk($sformatf("%s.tx[%0d]", tag, k), t, slots[k / cpb]);
      chk($sformatf("%s.busy[%0d]", tag, k), b, 1'b1);
      chk($sformatf("%s.tx_done[%0d]", tag, k), dn, 1'b0);
      if (k == inj) drive(sel, 1'b1, 8'h3C);
      if (k == inj + 1) drive(sel, 1'b0, 8'h3C);
      tick();
    end
    sample(sel, t, b, dn);
    chk({tag, ".end_tx"}, t, 1'b1);
    chk({tag, ".end_busy"}, b, 1'b0);
    chk({tag, ".end_tx_done"}, dn, 1'b1);
  endtask

  initial begin
    logic t, b, d;
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    tick();
    tick();
    chk_idle(0, "reset_even");
    chk_idle(1, "reset_odd");
    chk_idle(2, "reset_fast");
    rst = 1'b0;
    tick();
    chk_idle(0, "post_reset_even");

    // A5: even parity 0, odd parity 1
    send(0, 8'hA5, 4, 1, 1'b0, 1, 1'b0, -10, "even_A5");
    tick();
    chk_idle(0, "after_A5");
    send(1, 8'hA5, 4, 1, 1'b1, 1, 1'b0, -10, "odd_A5");
    send(0, 8'h07, 4, 1, 1'b1, 1, 1'b0, -10, "even_07");
    send(0, 8'hFF, 4, 1, 1'b0, 1, 1'b0, -10, "even_FF");

    // Request while busy is dropped, not queued
    send(0, 8'hA5, 4, 1, 1'b0, 1, 1'b0, 9, "ignore_A5");
    for (int i = 0; i < 50; i++) begin
      tick();
      chk_idle(0, $sformatf("ignore_quiet[%0d]", i));
    end

    // Back-to-back: tx_start stays high through tx_done
    send(0, 8'h55, 4, 1, 1'b0, 1, 1'b1, -10, "b2b_1");
    send(0, 8'h55, 4, 1, 1'b0, 1, 1'b0, -10, "b2b_2");
    tick();
    chk_idle(0, "b2b_after");

    // Reset mid-frame at cycle 20
    drive(0, 1'b1, 8'hA5);
    tick();
    drive(0, 1'b0, 8'hA5);
    for (int k = 0; k < 19; k++) tick();
    sample(0, t, b, d);
    chk("mid.pre_busy", b, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle(0, "mid_reset_edge");
    for (int i = 0; i < 30; i++) begin
      tick();
      chk_idle(0, $sformatf("mid_quiet[%0d]", i));
    end
    send(0, 8'h01, 4, 1, 1'b1, 1, 1'b0, -10, "after_rst_01");

    // Request coincident with reset is dropped
    rst = 1'b1;
    drive(0, 1'b1, 8'hA5);
    tick();
    rst = 1'b0;
    drive(0, 1'b0, 8'hA5);
    chk_idle(0, "start_with_rst");
    tick();
    chk_idle(0, "start_with_rst_next");

    // One clock per bit, no parity, two stops
    send(2, 8'h80, 1, 0, 1'b0, 2, 1'b0, -10, "fast_80");
    tick();
    chk_idle(2, "fast_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
